muxpga_cfg_loader: RTL and testbench

Host-side driver for the muxpga fabric pin interface. It sits in front of the fabric's 8-bit `io_in` bus and consumes its `io_out` bus. It shifts a configuration stream of `NIBBLES` nibbles into the fabric's config chain, optionally reads the chain back non-destructively and checks it against a checksum, then steps the fabric in run mode and returns the fabric's output byte per step.

---
 rtl/muxpga_cfg_loader.sv | 175 +++++++++++++++++
 tb/tb_muxpga_cfg_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muxpga_cfg_loader.sv
// rtl/muxpga_cfg_loader.sv - host-side config loader, readback checker and run stepper for the muxpga fabric
module muxpga_cfg_loader #(
  parameter int NIBBLES = 24
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       verify_en_i,
  input  logic       abort_i,
  input  logic [3:0] cfg_data_i,
  input  logic       cfg_valid_i,
  output logic       cfg_ready_o,
  input  logic [3:0] run_data_i,
  input  logic       run_valid_i,
  output logic [7:0] fab_io_in_o,
  input  logic [7:0] fab_io_out_i,
  output logic [7:0] result_o,
  output logic       result_valid_o,
  output logic       busy_o,
  output logic       cfg_done_o,
  output logic       cfg_error_o
);

  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] CMD_SHIFT = 2'd0;
  localparam logic [1:0] CMD_STEP  = 2'd1;
  localparam logic [1:0] CMD_HOLD  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_RUN,
    S_FAIL
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      rchk_q, rchk_d;
  logic            verify_q, verify_d;
  logic [7:0]      result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic            cfg_done_q, cfg_done_d;
  logic            cfg_error_q, cfg_error_d;
  logic [1:0]      cmd;
  logic [3:0]      nib;

  // Order-sensitive checksum: rotate left by one, fold the nibble into the low bits.
  function automatic logic [7:0] chk_next(input logic [7:0] c, input logic [3:0] n);
    return {c[6:0], c[7]} ^ {4'b0000, n};
  endfunction

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    chk_d          = chk_q;
    rchk_d         = rchk_q;
    verify_d       = verify_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    cfg_done_d     = cfg_done_q;
    cfg_error_d    = cfg_error_q;
    cmd            = CMD_HOLD;
    nib            = 4'h0;
    cfg_ready_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d     = S_LOAD;
          count_d     = '0;
          chk_d       = 8'h00;
          rchk_d      = 8'h00;
          cfg_done_d  = 1'b0;
          cfg_error_d = 1'b0;
          verify_d    = verify_en_i;
        end
      end
      S_LOAD: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          cmd   = CMD_SHIFT;
          nib   = cfg_data_i;
          chk_d = chk_next(chk_q, cfg_data_i);
          if (count_q == LAST) begin
            count_d = '0;
            state_d = verify_q ? S_VERIFY : S_RUN;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      S_VERIFY: begin
        // Feeding the chain tail back into its head rotates it once per cycle.
        cmd    = CMD_SHIFT;
        nib    = fab_io_out_i[7:4];
        rchk_d = chk_next(rchk_q, fab_io_out_i[7:4]);
        if (count_q == LAST) begin
          count_d = '0;
          state_d = (rchk_d == chk_q) ? S_RUN : S_FAIL;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_RUN: begin
        if (run_valid_i) begin
          cmd            = CMD_STEP;
          nib            = run_data_i;
          result_d       = fab_io_out_i;
          result_valid_d = 1'b1;
        end
        if (start_i && !abort_i) begin
          state_d     = S_LOAD;
          count_d     = '0;
          chk_d       = 8'h00;
          rchk_d      = 8'h00;
          cfg_done_d  = 1'b0;
          cfg_error_d = 1'b0;
          verify_d    = verify_en_i;
        end
      end
      S_FAIL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_i) begin
      state_d = S_IDLE;
    end
    if (state_d == S_RUN) begin
      cfg_done_d = 1'b1;
    end
    if (state_d == S_FAIL) begin
      cfg_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      chk_q          <= 8'h00;
      rchk_q         <= 8'h00;
      verify_q       <= 1'b0;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      cfg_done_q     <= 1'b0;
      cfg_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      chk_q          <= chk_d;
      rchk_q         <= rchk_d;
      verify_q       <= verify_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      cfg_done_q     <= cfg_done_d;
      cfg_error_q    <= cfg_error_d;
    end
  end

  assign fab_io_in_o    = {cmd, nib, 2'b00};
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign busy_o         = (state_q != S_IDLE);
  assign cfg_done_o     = cfg_done_q;
  assign cfg_error_o    = cfg_error_q;

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// tb/tb_muxpga_cfg_loader.sv - directed plus randomized bench for muxpga_cfg_loader with a behavioural fabric
module tb_muxpga_cfg_loader;

  localparam int NIB = 24;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       verify_en;
  logic       abort;
  logic [3:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] run_data;
  logic       run_valid;
  logic [7:0] fab_io_in;
  logic [7:0] fab_io_out;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic       cfg_done;
  logic       cfg_error;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muxpga_cfg_loader #(.NIBBLES(NIB)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .verify_en_i    (verify_en),
    .abort_i        (abort),
    .cfg_data_i     (cfg_data),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .run_data_i     (run_data),
    .run_valid_i    (run_valid),
    .fab_io_in_o    (fab_io_in),
    .fab_io_out_i   (fab_io_out),
    .result_o       (result),
    .result_valid_o (result_valid),
    .busy_o         (busy),
    .cfg_done_o     (cfg_done),
    .cfg_error_o    (cfg_error)
  );

  // Fabric model: a nibble shift chain plus four byte-wide rows that pass data downward
  // when every cell is configured as cfg=2 / mux=0.
  logic [3:0] chain [NIB];
  logic [7:0] rows [4];
  logic       mode_q;
  logic       corrupt = 1'b0;
  wire  [1:0] fcmd = fab_io_in[7:6];
  wire  [3:0] fnib = fab_io_in[5:2];

  assign fab_io_out = mode_q ? rows[3] : {(corrupt ? 4'h0 : chain[NIB-1]), 4'h0};

  function automatic bit pass_cfg();
    for (int i = 0; i < NIB; i++) begin
      if (i % 2 == 1 && chain[i] != 4'h2) return 1'b0;
      if (i % 2 == 0 && chain[i] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NIB; i++) chain[i] <= 4'h0;
      for (int r = 0; r < 4; r++) rows[r] <= 8'h00;
      mode_q <= 1'b0;
    end else begin
      mode_q <= (fcmd != 2'd0);
      if (fcmd == 2'd0) begin
        for (int i = NIB - 1; i > 0; i--) chain[i] <= chain[i-1];
        chain[0] <= fnib;
      end else if (fcmd == 2'd1) begin
        rows[0] <= pass_cfg() ? {fnib, fnib} : 8'h00;
        rows[1] <= rows[0];
        rows[2] <= rows[1];
        rows[3] <= rows[2];
      end
    end
  end

  logic [3:0] sent [$];
  logic [3:0] hist [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit chain_matches();
    for (int k = 0; k < NIB; k++) begin
      if (chain[NIB-1-k] != sent[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int cksum();
    int c = 0;
    foreach (sent[i]) c = (((c * 2) % 256) + (c / 128)) ^ int'(sent[i]);
    return c;
  endfunction

  task automatic do_start(input logic v);
    start     = 1'b1;
    verify_en = v;
    @(posedge clk); #1;
    start     = 1'b0;
    verify_en = 1'($urandom);
    check("start_busy", 32'(busy), 1);
    check("start_done_clr", 32'(cfg_done), 0);
    check("start_err_clr", 32'(cfg_error), 0);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic feed(input int mode);
    int idx = 0;
    int cyc = 0;
    int shifts = 0;
    logic v;
    while (idx < NIB && cyc < 400) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom);
      cfg_valid = v;
      cfg_data  = v ? sent[idx] : 4'($urandom);
      @(negedge clk);
      check("load_ready", 32'(cfg_ready), 1);
      check("load_cmd", 32'(fab_io_in[7:6]), v ? 0 : 2);
      if (v) check("load_nib", 32'(fab_io_in[5:2]), 32'(sent[idx]));
      if (fab_io_in[7:6] == 2'd0) shifts++;
      @(posedge clk); #1;
      if (v) idx++;
      cyc++;
    end
    cfg_valid = 1'b0;
    check("load_accepts", idx, NIB);
    check("load_shifts", shifts, NIB);
    if (mode == 0) check("load_cycles", cyc, NIB);
    if (mode == 1) check("load_cycles", cyc, 2 * NIB - 1);
  endtask

  task automatic readback(input bit corrupted);
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      check("vfy_cmd", 32'(fab_io_in[7:6]), 0);
      check("vfy_nib", 32'(fab_io_in[5:2]), corrupted ? 0 : 32'(sent[k]));
      check("vfy_ready", 32'(cfg_ready), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] exp_res;
    logic       prev_step;
    logic       step;
    logic [3:0] d;
    bit         exp_err;

    reset = 1'b1; start = 1'b0; verify_en = 1'b0; abort = 1'b0;
    cfg_data = 4'h0; cfg_valid = 1'b0; run_data = 4'h0; run_valid = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_io_in", 32'(fab_io_in), 32'h80);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(cfg_done), 0);
    check("rst_err", 32'(cfg_error), 0);
    check("rst_rv", 32'(result_valid), 0);
    check("rst_ready", 32'(cfg_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // load 0..F,0..7 with valid toggling, no verify
    sent.delete();
    for (int k = 0; k < NIB; k++) sent.push_back(4'(k % 16));
    do_start(1'b0);
    feed(1);
    check("nv_done", 32'(cfg_done), 1);
    check("nv_busy", 32'(busy), 1);
    check("nv_chain", 32'(chain_matches()), 1);

    // load 5,A pattern with verify; chain must be restored afterwards
    sent.delete();
    for (int k = 0; k < NIB; k++) sent.push_back((k % 2 == 0) ? 4'h5 : 4'hA);
    do_start(1'b1);
    feed(0);
    check("v5a_not_done", 32'(cfg_done), 0);
    readback(1'b0);
    check("v5a_done", 32'(cfg_done), 1);
    check("v5a_err", 32'(cfg_error), 0);
    check("v5a_restored", 32'(chain_matches()), 1);

    // random data with random gaps and verify
    sent.delete();
    for (int k = 0; k < NIB; k++) sent.push_back(4'($urandom));
    do_start(1'b1);
    feed(2);
    readback(1'b0);
    check("vrnd_done", 32'(cfg_done), 1);
    check("vrnd_err", 32'(cfg_error), 0);
    check("vrnd_restored", 32'(chain_matches()), 1);

    // corrupted readback
    sent.delete();
    for (int k = 0; k < NIB; k++) sent.push_back(4'($urandom_range(15, 1)));
    exp_err = (cksum() != 0);
    do_start(1'b1);
    feed(2);
    corrupt = 1'b1;
    readback(1'b1);
    corrupt = 1'b0;
    check("bad_err", 32'(cfg_error), 32'(exp_err));
    @(posedge clk); #1;
    check("bad_busy", 32'(busy), 32'(!exp_err));
    check("bad_done", 32'(cfg_done), 32'(!exp_err));
    check("bad_err_sticky", 32'(cfg_error), 32'(exp_err));
    check("bad_io_in", 32'(fab_io_in), exp_err ? 32'h80 : 32'h80);

    // pass-through config, then run steps
    sent.delete();
    for (int k = 0; k < NIB; k++) sent.push_back((k % 2 == 0) ? 4'h2 : 4'h0);
    do_start(1'b0);
    feed(0);
    @(negedge clk);
    check("run_cfg_done", 32'(cfg_done), 1);
    check("run_hold_cmd", 32'(fab_io_in[7:6]), 2);
    @(posedge clk); #1;
    exp_res   = 8'h00;
    prev_step = 1'b0;
    hist.delete();
    for (int c = 0; c < 40; c++) begin
      step = (c < 5) ? 1'b1 : (c == 5) ? 1'b0 : 1'($urandom);
      d    = (c < 5) ? 4'h9 : 4'($urandom);
      run_valid = step;
      run_data  = d;
      @(negedge clk);
      check("run_rv", 32'(result_valid), 32'(prev_step));
      check("run_result", 32'(result), 32'(exp_res));
      if (c == 5) check("run_99", 32'(result), 32'h99);
      check("run_cmd", 32'(fab_io_in[7:6]), step ? 1 : 2);
      if (step) begin
        check("run_nib", 32'(fab_io_in[5:2]), 32'(d));
        exp_res = (hist.size() >= 4) ? {hist[hist.size()-4], hist[hist.size()-4]} : 8'h00;
        hist.push_back(d);
      end
      prev_step = step;
      @(posedge clk); #1;
    end
    run_valid = 1'b0;
    @(negedge clk);
    check("run_rv_last", 32'(result_valid), 32'(prev_step));
    @(posedge clk); #1;

    // abort mid-load, ignored start during load, then a clean reload
    do_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 4'($urandom);
      start     = (i == 5);
      @(negedge clk);
      check("ab_cmd", 32'(fab_io_in[7:6]), 0);
      check("ab_ready", 32'(cfg_ready), 1);
      @(posedge clk); #1;
    end
    start     = 1'b0;
    cfg_valid = 1'b0;
    abort     = 1'b1;
    @(negedge clk);
    check("ab_busy_before", 32'(busy), 1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("ab_busy", 32'(busy), 0);
    check("ab_ready_idle", 32'(cfg_ready), 0);
    check("ab_io_in", 32'(fab_io_in), 32'h80);
    check("ab_done", 32'(cfg_done), 0);
    @(posedge clk); #1;
    sent.delete();
    for (int k = 0; k < NIB; k++) sent.push_back(4'($urandom));
    do_start(1'b0);
    feed(0);
    check("re_done", 32'(cfg_done), 1);
    check("re_busy", 32'(busy), 1);
    check("re_ready", 32'(cfg_ready), 0);
    check("re_chain", 32'(chain_matches()), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
